// File: rtl/game_timing_pkg.sv
// Shared frame-timing definitions used by the rate divider and by
// frame_tick_scheduler, so both sides agree on the frame period and on
// the countdown timer state encoding.
package game_timing_pkg;

  // Width of frame counters and countdown lengths.
  localparam int FRAME_W        = 16;
  // clk cycles without an enable change before the watchdog flags a stall.
  localparam int STALL_CYCLES   = 4000000;
  // Width of the watchdog gap counter; must hold STALL_CYCLES.
  localparam int GAP_W          = 23;
  // Rate-divider reload: 50 MHz / 1666666 toggles gives ~30 level changes/s.
  localparam int DIVIDER_RELOAD = 1666666;

  // Countdown timer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

endpackage

// File: rtl/frame_tick_scheduler_if.sv
// Countdown timer control/status bundle between the game-control FSM
// (master) and frame_tick_scheduler (slave).
//
// Signalling: there is no valid/ready handshake. start and abort are
// single-cycle request pulses acted on in the cycle they are high
// (abort wins over start); pause is a level; load_frames is sampled only
// while start is high. frames_left/timer_busy are registered status and
// timer_expired is a one-cycle pulse; the master may sample them any cycle.
interface frame_tick_scheduler_if #(
  parameter int FRAME_W = game_timing_pkg::FRAME_W
);
  logic               start;
  logic               pause;
  logic               abort;
  logic [FRAME_W-1:0] load_frames;
  logic [FRAME_W-1:0] frames_left;
  logic               timer_busy;
  logic               timer_expired;

  modport master (
    output start, pause, abort, load_frames,
    input  frames_left, timer_busy, timer_expired
  );

  modport slave (
    input  start, pause, abort, load_frames,
    output frames_left, timer_busy, timer_expired
  );
endinterface

// File: rtl/frame_tick_scheduler_edge.sv
// toggle_edge_detect: turns a toggle-per-event level into a registered
// one-cycle pulse per level change (rising or falling).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   level_in      toggling level, same clock domain, reset level 0
//   change        combinational: level_in differs from the last sampled level
//   tick          registered change, high for exactly one cycle per change
module toggle_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level_in,
  output logic change,
  output logic tick
);

  logic prev_level;

  assign change = (level_in != prev_level);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_level <= 1'b0;
      tick       <= 1'b0;
    end else begin
      prev_level <= level_in;
      tick       <= change;
    end
  end

endmodule

// File: rtl/frame_tick_scheduler.sv
// frame_tick_scheduler: consumer end of the frame-rate enable.
// Converts each enable_in level change into a one-cycle frame_tick,
// counts frames, runs a frame-granular countdown timer and flags a stall
// when the divider stops toggling.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   enable_in     toggle-per-frame level from the rate divider
//   tmr           countdown control/status (start/pause/abort/load_frames in,
//                 frames_left/timer_busy/timer_expired out)
//   frame_tick    one-cycle pulse per enable_in change
//   frame_count   free-running wrapping count of frame_tick pulses
//   stall         high while enable_in has not changed for STALL_CYCLES cycles
//   state_dbg     current countdown state, for debug and checkers
module frame_tick_scheduler #(
  parameter int FRAME_W      = game_timing_pkg::FRAME_W,
  parameter int STALL_CYCLES = game_timing_pkg::STALL_CYCLES,
  parameter int GAP_W        = game_timing_pkg::GAP_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable_in,
  frame_tick_scheduler_if.slave         tmr,
  output logic                          frame_tick,
  output logic [FRAME_W-1:0]            frame_count,
  output logic                          stall,
  output game_timing_pkg::timer_state_t state_dbg
);
  import game_timing_pkg::*;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STALL_CYCLES - 1);

  logic en_change;

  toggle_edge_detect u_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .level_in (enable_in),
    .change   (en_change),
    .tick     (frame_tick)
  );

  // Frame counter: advances at the same edge that raises frame_tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (en_change) begin
      frame_count <= frame_count + FRAME_W'(1);
    end
  end

  // Stall watchdog: gap saturates at STALL_CYCLES-1 so stall stays up
  // until the next change without the counter wrapping.
  logic [GAP_W-1:0] gap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap   <= '0;
      stall <= 1'b0;
    end else if (en_change) begin
      gap   <= '0;
      stall <= 1'b0;
    end else if (gap == GAP_LAST) begin
      stall <= 1'b1;
    end else begin
      gap <= gap + GAP_W'(1);
    end
  end

  // Countdown FSM. It consumes the registered frame_tick, so a decrement
  // lands one cycle after the tick is visible. Priority: abort > start >
  // pause > tick.
  timer_state_t       state, state_n;
  logic [FRAME_W-1:0] left_q, left_n;
  logic               expired_n;
  logic               busy_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      left_q            <= '0;
      tmr.timer_expired <= 1'b0;
      tmr.timer_busy    <= 1'b0;
    end else begin
      state             <= state_n;
      left_q            <= left_n;
      tmr.timer_expired <= expired_n;
      tmr.timer_busy    <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    left_n    = left_q;
    expired_n = 1'b0;
    if (tmr.abort) begin
      state_n = IDLE;
      left_n  = '0;
    end else if (tmr.start) begin
      // A tick in the same cycle is dropped: the load value is taken as is.
      if (tmr.load_frames == '0) begin
        state_n   = EXPIRED;
        left_n    = '0;
        expired_n = 1'b1;
      end else begin
        state_n = RUNNING;
        left_n  = tmr.load_frames;
      end
    end else begin
      unique case (state)
        RUNNING: begin
          if (tmr.pause) begin
            // Entering PAUSED swallows any tick in this cycle.
            state_n = PAUSED;
          end else if (frame_tick) begin
            left_n = left_q - FRAME_W'(1);
            if (left_q == FRAME_W'(1)) begin
              state_n   = EXPIRED;
              expired_n = 1'b1;
            end
          end
        end
        PAUSED: begin
          // Ticks while paused are lost, not queued.
          if (!tmr.pause) begin
            state_n = RUNNING;
          end
        end
        default: begin
          // IDLE and EXPIRED wait for start or abort.
        end
      endcase
    end
    busy_n = (state_n == RUNNING) || (state_n == PAUSED);
  end

  assign tmr.frames_left = left_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_frame_tick_scheduler.sv
module tb_frame_tick_scheduler;
  import game_timing_pkg::*;

  localparam int FW    = 16;
  localparam int STALL = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  logic enable_in;
  always #5 clk = ~clk;

  logic          frame_tick;
  logic [FW-1:0] frame_count;
  logic          stall;
  timer_state_t  state_dbg;

  frame_tick_scheduler_if #(.FRAME_W(FW)) tmr ();

  frame_tick_scheduler #(
    .FRAME_W(FW), .STALL_CYCLES(STALL), .GAP_W(23)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable_in   (enable_in),
    .tmr         (tmr),
    .frame_tick  (frame_tick),
    .frame_count (frame_count),
    .stall       (stall),
    .state_dbg   (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: frame_count value expected with each tick pulse.
  logic [FW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Behavioural view: the level last seen, the cycles since the last
  // change, and the timer as (mode, frames remaining).
  logic          m_prev, m_tick, m_stall, m_exp;
  logic [FW-1:0] m_count, m_left;
  int            m_since;
  timer_state_t  m_state;

  task automatic model_reset();
    m_prev = 1'b0; m_tick = 1'b0; m_stall = 1'b0; m_exp = 1'b0;
    m_count = '0; m_left = '0; m_since = 0; m_state = IDLE;
  endtask

  // Advance one clock: evaluate the spec rules on pre-edge inputs, then
  // step past the edge and settle.
  task automatic cycle();
    logic          chg, lvl, n_exp;
    timer_state_t  n_state;
    logic [FW-1:0] n_left;
    lvl     = enable_in;
    chg     = (lvl !== m_prev);
    n_state = m_state;
    n_left  = m_left;
    n_exp   = 1'b0;
    if (tmr.abort) begin
      n_state = IDLE; n_left = '0;
    end else if (tmr.start) begin
      if (tmr.load_frames == 0) begin
        n_state = EXPIRED; n_left = '0; n_exp = 1'b1;
      end else begin
        n_state = RUNNING; n_left = tmr.load_frames;
      end
    end else if (m_state == RUNNING && tmr.pause) begin
      n_state = PAUSED;
    end else if (m_state == PAUSED) begin
      if (!tmr.pause) n_state = RUNNING;
    end else if (m_state == RUNNING && m_tick) begin
      n_left = m_left - 1;
      if (n_left == 0) begin n_state = EXPIRED; n_exp = 1'b1; end
    end
    @(posedge clk);
    m_prev  = lvl;
    m_tick  = chg;
    if (chg) begin
      m_count = m_count + 1;
      m_since = 0;
    end else if (m_since < 1000000) begin
      m_since = m_since + 1;
    end
    m_stall = (m_since >= STALL);
    m_state = n_state;
    m_left  = n_left;
    m_exp   = n_exp;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    tmr.start = 1'b0; tmr.pause = 1'b0; tmr.abort = 1'b0; tmr.load_frames = '0;
  endtask

  task automatic pulse_start(input logic [FW-1:0] load);
    tmr.start = 1'b1; tmr.load_frames = load;
    cycle();
    tmr.start = 1'b0;
  endtask

  // One enable change; returns once the decrement from its tick has landed.
  task automatic frame();
    enable_in = ~enable_in;
    cycle();
    cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; enable_in = 1'b0; idle_inputs(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (frame_tick !== 1'b0 || frame_count !== '0 || tmr.frames_left !== '0 ||
        tmr.timer_busy !== 1'b0 || tmr.timer_expired !== 1'b0 || stall !== 1'b0 ||
        state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_values: tick=%b count=%0d left=%0d busy=%b exp=%b stall=%b state=%s, need all 0 and IDLE",
               frame_tick, frame_count, tmr.frames_left, tmr.timer_busy, tmr.timer_expired, stall, state_dbg.name());
    end
    reset_n = 1'b1;
    repeat (3) cycle();
    checks++;
    if (frame_tick !== 1'b0 || frame_count !== '0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: tick=%b count=%0d stall=%b, need 0/0/0", frame_tick, frame_count, stall);
    end
  endtask

  task automatic test_ticks();
    int            pulses;
    logic [FW-1:0] base;
    pulses = 0;
    base   = m_count;
    for (int i = 0; i < 5; i++) begin
      enable_in = ~enable_in;
      for (int j = 0; j < 10; j++) begin
        cycle();
        if (m_tick) exp_q.push_back(m_count);
        checks++;
        if (frame_tick !== (j == 0)) begin
          errors++;
          $display("FAIL tick_latency: change %0d cycle %0d tick=%b need %b", i, j, frame_tick, (j == 0));
        end
        if (frame_tick) begin
          pulses++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tick_unexpected: tick with count=%0d, none expected", frame_count);
          end else begin
            logic [FW-1:0] e;
            e = exp_q.pop_front();
            if (frame_count !== e) begin
              errors++;
              $display("FAIL tick_count: count=%0d need %0d", frame_count, e);
            end
          end
        end
      end
    end
    checks++;
    if (pulses != 5 || frame_count !== base + FW'(5) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL tick_total: pulses=%0d count=%0d pending=%0d, need 5 pulses count=%0d pending=0",
               pulses, frame_count, exp_q.size(), base + FW'(5));
    end
  endtask

  task automatic test_stall();
    int rise_at;
    rise_at = -1;
    enable_in = ~enable_in;
    cycle();
    for (int k = 1; k <= 25; k++) begin
      cycle();
      if (stall === 1'b1 && rise_at < 0) rise_at = k;
      checks++;
      if (stall !== (k >= STALL) || stall !== m_stall) begin
        errors++;
        $display("FAIL stall_level: %0d cycles after change stall=%b need %b", k, stall, (k >= STALL));
      end
    end
    checks++;
    if (rise_at != STALL) begin
      errors++;
      $display("FAIL stall_rise: rose %0d cycles after change, need %0d", rise_at, STALL);
    end
    enable_in = ~enable_in;
    cycle();
    checks++;
    if (frame_tick !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear: tick=%b stall=%b, need tick=1 stall=0", frame_tick, stall);
    end
  endtask

  task automatic test_countdown();
    int exp_pulses;
    exp_pulses = 0;
    idle_inputs();
    pulse_start(FW'(3));
    checks++;
    if (tmr.frames_left !== FW'(3) || tmr.timer_busy !== 1'b1 || state_dbg !== RUNNING) begin
      errors++;
      $display("FAIL countdown_load: left=%0d busy=%b state=%s, need 3/1/RUNNING",
               tmr.frames_left, tmr.timer_busy, state_dbg.name());
    end
    for (int t = 1; t <= 5; t++) begin
      enable_in = ~enable_in;
      cycle();
      if (tmr.timer_expired) exp_pulses++;
      cycle();
      if (tmr.timer_expired) exp_pulses++;
      checks++;
      if (tmr.frames_left !== ((t < 3) ? FW'(3 - t) : FW'(0)) || tmr.frames_left !== m_left ||
          tmr.timer_expired !== (t == 3) || tmr.timer_busy !== (t < 3)) begin
        errors++;
        $display("FAIL countdown_step: tick %0d left=%0d exp=%b busy=%b, need left=%0d exp=%b busy=%b",
                 t, tmr.frames_left, tmr.timer_expired, tmr.timer_busy,
                 (t < 3) ? 3 - t : 0, (t == 3), (t < 3));
      end
    end
    checks++;
    if (exp_pulses != 1 || state_dbg !== EXPIRED) begin
      errors++;
      $display("FAIL countdown_expire_once: pulses=%0d state=%s, need 1 and EXPIRED", exp_pulses, state_dbg.name());
    end
  endtask

  task automatic test_pause();
    idle_inputs();
    pulse_start(FW'(4));
    frame();
    tmr.pause = 1'b1;
    cycle();
    for (int t = 0; t < 3; t++) frame();
    checks++;
    if (tmr.frames_left !== FW'(3) || state_dbg !== PAUSED || tmr.timer_busy !== 1'b1) begin
      errors++;
      $display("FAIL pause_hold: left=%0d state=%s busy=%b, need 3/PAUSED/1",
               tmr.frames_left, state_dbg.name(), tmr.timer_busy);
    end
    tmr.pause = 1'b0;
    cycle();
    for (int t = 1; t <= 3; t++) begin
      frame();
      checks++;
      if (tmr.frames_left !== FW'(3 - t) || tmr.timer_expired !== (t == 3) || tmr.frames_left !== m_left) begin
        errors++;
        $display("FAIL pause_resume: counted tick %0d left=%0d exp=%b, need left=%0d exp=%b",
                 t + 1, tmr.frames_left, tmr.timer_expired, 3 - t, (t == 3));
      end
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    pulse_start(FW'(2));
    enable_in = ~enable_in;
    cycle();
    tmr.start = 1'b1; tmr.load_frames = FW'(5);
    cycle();
    tmr.start = 1'b0;
    checks++;
    if (tmr.frames_left !== FW'(5) || state_dbg !== RUNNING) begin
      errors++;
      $display("FAIL start_with_tick: left=%0d state=%s, need 5/RUNNING", tmr.frames_left, state_dbg.name());
    end
    tmr.abort = 1'b1; tmr.start = 1'b1; tmr.load_frames = FW'(9);
    cycle();
    idle_inputs();
    checks++;
    if (state_dbg !== IDLE || tmr.frames_left !== '0 || tmr.timer_busy !== 1'b0 || tmr.timer_expired !== 1'b0) begin
      errors++;
      $display("FAIL abort_over_start: state=%s left=%0d busy=%b exp=%b, need IDLE/0/0/0",
               state_dbg.name(), tmr.frames_left, tmr.timer_busy, tmr.timer_expired);
    end
    pulse_start(FW'(0));
    checks++;
    if (tmr.timer_expired !== 1'b1 || state_dbg !== EXPIRED || tmr.frames_left !== '0) begin
      errors++;
      $display("FAIL start_zero: exp=%b state=%s left=%0d, need 1/EXPIRED/0",
               tmr.timer_expired, state_dbg.name(), tmr.frames_left);
    end
    cycle();
    checks++;
    if (tmr.timer_expired !== 1'b0) begin
      errors++;
      $display("FAIL start_zero_pulse_width: exp=%b one cycle later, need 0", tmr.timer_expired);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ((i % 400) < 360 && $urandom_range(0, 4) == 0) enable_in = ~enable_in;
      tmr.start       = ($urandom_range(0, 30) == 0);
      tmr.abort       = ($urandom_range(0, 70) == 0);
      tmr.load_frames = FW'($urandom_range(0, 6));
      if ($urandom_range(0, 25) == 0) tmr.pause = ~tmr.pause;
      cycle();
      checks++;
      if (frame_tick !== m_tick || frame_count !== m_count || stall !== m_stall ||
          tmr.frames_left !== m_left || tmr.timer_expired !== m_exp ||
          tmr.timer_busy !== (m_state == RUNNING || m_state == PAUSED) || state_dbg !== m_state) begin
        errors++;
        $display("FAIL random_cycle %0d: tick=%b/%b count=%0d/%0d stall=%b/%b left=%0d/%0d exp=%b/%b busy=%b state=%s/%s (got/need)",
                 i, frame_tick, m_tick, frame_count, m_count, stall, m_stall, tmr.frames_left, m_left,
                 tmr.timer_expired, m_exp, tmr.timer_busy, state_dbg.name(), m_state.name());
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    pulse_start(FW'(7));
    checks++;
    if (tmr.frames_left !== FW'(7)) begin
      errors++;
      $display("FAIL areset_setup: left=%0d need 7", tmr.frames_left);
    end
    #3;
    reset_n = 1'b0; enable_in = 1'b0;
    #1;
    model_reset();
    checks++;
    if (frame_tick !== 1'b0 || frame_count !== '0 || tmr.frames_left !== '0 || tmr.timer_busy !== 1'b0 ||
        tmr.timer_expired !== 1'b0 || stall !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL areset_immediate: tick=%b count=%0d left=%0d busy=%b exp=%b stall=%b state=%s, need all 0/IDLE",
               frame_tick, frame_count, tmr.frames_left, tmr.timer_busy, tmr.timer_expired, stall, state_dbg.name());
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle();
    enable_in = 1'b1;
    cycle();
    checks++;
    if (frame_tick !== 1'b1 || frame_count !== FW'(1) || tmr.frames_left !== '0) begin
      errors++;
      $display("FAIL areset_first_tick: tick=%b count=%0d left=%0d, need 1/1/0", frame_tick, frame_count, tmr.frames_left);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_ticks();
    test_stall();
    test_countdown();
    test_pause();
    test_priority();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_tick_scheduler.md
Name: frame_tick_scheduler

Overview:
- Consumer end of the frame-rate enable: takes the toggling enable produced by the rate divider (one level change per frame) and turns each change into a one-cycle frame_tick pulse.
- Also counts frames, runs a frame-granular countdown timer for game rounds, and raises a stall flag if the divider stops toggling.
- Sits between the rate divider and the game-control FSM, which uses frame_tick and timer_expired in place of raw toggles.

Parameters:
- FRAME_W, 16, width of frame_count, load_frames and frames_left.
- STALL_CYCLES, 4000000, clk cycles without an enable_in change before stall asserts; legal range 2..2^23-1.
- GAP_W, 23, width of the internal gap counter; must hold STALL_CYCLES.

Ports:
- clk  in  1  system clock (50 MHz board clock).
- reset_n  in  1  asynchronous active-low reset.
- enable_in  in  1  toggle-per-frame level from the rate divider; same clock domain; reset level 0.
- start  in  1  one-cycle pulse: load load_frames and run the countdown.
- pause  in  1  level: hold the countdown while high.
- abort  in  1  one-cycle pulse: stop the countdown and return to IDLE.
- load_frames  in  FRAME_W  countdown length in frames, sampled on start.
- frame_tick  out  1  one-cycle pulse per enable_in change.
- frame_count  out  FRAME_W  free-running count of frame_tick pulses, wraps.
- frames_left  out  FRAME_W  remaining countdown frames.
- timer_busy  out  1  high in RUNNING or PAUSED.
- timer_expired  out  1  one-cycle pulse when the countdown reaches 0.
- stall  out  1  high while no enable_in change has occurred for STALL_CYCLES cycles.

Behaviour:
- Reset is asynchronous and active-low on a single clock. Reset values: prev_en=0, frame_tick=0, frame_count=0, frames_left=0, timer_busy=0, timer_expired=0, stall=0, gap=0, state=IDLE. Reset mid-countdown discards the countdown.
- Edge detect:
  - prev_en <= enable_in every cycle.
  - frame_tick <= (enable_in != prev_en), registered.
  - Latency: frame_tick is high for exactly one cycle, in the cycle after the first clk edge at which the new enable_in level is sampled.
  - Both rising and falling enable_in changes produce a tick.
- frame_count increments in the same cycle frame_tick is high and wraps from 2^FRAME_W-1 to 0.
- Stall watchdog:
  - On an enable_in change (same condition as the tick), gap <= 0 and stall <= 0.
  - Otherwise, if gap == STALL_CYCLES-1 then stall <= 1 and gap holds; else gap <= gap+1.
  - stall is therefore high from cycle STALL_CYCLES after the last change and clears in the cycle frame_tick rises.
- Countdown FSM, states IDLE, RUNNING, PAUSED, EXPIRED:
  - Priority per cycle: abort > start > pause > frame_tick.
  - abort: state <= IDLE, frames_left <= 0, no expired pulse.
  - start, from any state including RUNNING (restart):
    - If load_frames==0: frames_left <= 0, state <= EXPIRED, timer_expired pulses next cycle.
    - Else: frames_left <= load_frames, state <= RUNNING.
  - RUNNING:
    - pause high: go to PAUSED; a tick in the same cycle is ignored.
    - Else on frame_tick: frames_left <= frames_left-1.
    - If frames_left was 1: state <= EXPIRED and timer_expired <= 1 for one cycle.
  - PAUSED: frames_left frozen; pause low returns to RUNNING the next cycle; ticks are lost, not queued.
  - EXPIRED: frames_left stays 0 until start or abort.
- timer_busy = (state==RUNNING || state==PAUSED), registered with the state.
- A start pulse in the same cycle as a tick loads load_frames unmodified (the tick is not applied).
- frame_count and the watchdog are independent of the FSM and of pause/abort.

Decomposition:
- Shared package (game_timing_pkg): FRAME_W, STALL_CYCLES, the timer state enum (IDLE/RUNNING/PAUSED/EXPIRED), and the divider reload constant 1666666 so divider and scheduler agree on frame period.
- One natural sub-module: toggle_edge_detect (prev_en register plus the registered change pulse), reusable for other toggle-style enables. Watchdog and FSM stay in the top.

Test Plan:
- Reset, then toggle enable_in every 10 cycles for 5 changes (0→1→0→1→0→1) -> exactly 5 one-cycle frame_tick pulses, each one cycle after its change; frame_count=5.
- With STALL_CYCLES=20, hold enable_in constant for 25 cycles after a change -> stall rises 20 cycles after the change; next change -> stall=0 in the frame_tick cycle.
- start with load_frames=3, then 3 ticks -> frames_left 3,2,1,0; timer_expired pulses once on the third tick; timer_busy drops; further ticks leave frames_left=0.
- load_frames=4: start, 1 tick, pause for 3 ticks, release, 3 ticks -> frames_left 3 held through pause; expired on the 4th counted tick (7th overall).
- Same-cycle start (load_frames=5) + tick while RUNNING with frames_left=2 -> frames_left=5. Same-cycle abort + start -> IDLE, frames_left=0. start with load_frames=0 -> timer_expired next cycle.
- Assert reset_n low mid-countdown (frames_left=7) between clock edges -> all outputs 0 immediately; after release, first enable_in change 0→1 still ticks.
